// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Imported by the responder, its RAM and the bench.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] STRB_WORD = 4'b1111;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_BYTE = 4'b0001;

  typedef struct packed {
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the MEM stage and the responder.
// master = pipeline side, slave = memory side.
interface dmem_responder_if #(
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_strb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_strb, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_strb, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_responder_byte_lane_ram.sv
// Word-addressed RAM with per-byte write enables.
// Synchronous write, combinational read, contents not reset.
module byte_lane_ram #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: one outstanding load/store,
// programmable wait states, registered response.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input logic              clk,
  input logic              rst_n,
  dmem_responder_if.slave  bus
);

  localparam int         IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  req_t              cur;
  logic [ADDR_W-1:0] cur_addr;
  logic              idle;
  logic              commit;
  logic              bad;
  logic [3:0]        ram_we;
  logic [31:0]       ram_rdata;

  assign idle = (state_q == ST_IDLE);

  // With zero wait states the commit happens on the
  // acceptance edge, before the capture regs are loaded.
  always_comb begin
    cur      = req_q;
    cur_addr = addr_q;
    if (idle) begin
      cur.we    = bus.req_we;
      cur.strb  = bus.req_strb;
      cur.wdata = bus.req_wdata;
      cur_addr  = bus.req_addr;
    end
  end

  assign bad = (cur_addr[1:0] != 2'b00)
             | (|cur_addr[ADDR_W-1:IDX_W+2]);

  assign ram_we = (commit & cur.we & ~bad)
                ? cur.strb : 4'b0000;

  byte_lane_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (cur_addr[IDX_W+1:2]),
    .wdata (cur.wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    addr_d      = addr_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    commit      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          req_d  = cur;
          addr_d = cur_addr;
          cnt_d  = WS;
          if (WS == 4'd0) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rdata_d     = 32'h0;
          err_d       = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (commit) begin
      rsp_valid_d = 1'b1;
      err_d       = bad;
      rdata_d     = (cur.we | bad) ? 32'h0 : ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      req_q       <= '0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_ready = idle;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table vectors on a WAIT_STATES=1
// instance, hand sequences on a WAIT_STATES=3 instance.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          hold;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        sel;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        o_req_ready, o_rsp_valid, o_rsp_err;
  logic [31:0] o_rsp_rdata;

  int   nvec = 0;
  int   nmis = 0;
  exp_t sb[$];
  vec_t tbl[$];

  dmem_responder_if #(.ADDR_W(32)) b1 ();
  dmem_responder_if #(.ADDR_W(32)) b3 ();

  assign b1.req_valid = req_valid & ~sel;
  assign b1.rsp_ready = rsp_ready & ~sel;
  assign b1.req_we    = req_we;
  assign b1.req_addr  = req_addr;
  assign b1.req_wdata = req_wdata;
  assign b1.req_strb  = req_strb;
  assign b3.req_valid = req_valid & sel;
  assign b3.rsp_ready = rsp_ready & sel;
  assign b3.req_we    = req_we;
  assign b3.req_addr  = req_addr;
  assign b3.req_wdata = req_wdata;
  assign b3.req_strb  = req_strb;

  assign o_req_ready = sel ? b3.req_ready : b1.req_ready;
  assign o_rsp_valid = sel ? b3.rsp_valid : b1.rsp_valid;
  assign o_rsp_rdata = sel ? b3.rsp_rdata : b1.rsp_rdata;
  assign o_rsp_err   = sel ? b3.rsp_err   : b1.rsp_err;

  dmem_responder #(
    .ADDR_W(32), .DEPTH(1024), .WAIT_STATES(1)
  ) u_ws1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  dmem_responder #(
    .ADDR_W(32), .DEPTH(1024), .WAIT_STATES(3)
  ) u_ws3 (
    .clk(clk), .rst_n(rst_n), .bus(b3)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic we,
                     input logic [31:0] addr,
                     input logic [31:0] wdata,
                     input logic [3:0] strb,
                     input int hold,
                     input logic [31:0] rdata,
                     input logic err);
    tbl.push_back('{we, addr, wdata, strb,
                    hold, rdata, err});
  endtask

  task automatic xact(input vec_t v, input int exp_lat);
    int   n;
    int   lat;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_strb  = v.strb;
    rsp_ready = 1'b0;
    n = 0;
    while (!o_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", n < 50, 1);
    sb.push_back('{v.rdata, v.err});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 1;
    while (!o_rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("busy_ready", o_req_ready, 0);
    e = sb[0];
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", o_rsp_valid, 1);
      chk("hold_rdata", o_rsp_rdata, e.rdata);
      chk("hold_ready", o_req_ready, 0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    e = sb.pop_front();
    chk("rsp_rdata", o_rsp_rdata, e.rdata);
    chk("rsp_err", o_rsp_err, e.err);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("post_valid", o_rsp_valid, 0);
    chk("post_ready", o_req_ready, 1);
    chk("post_rdata", o_rsp_rdata, 0);
    chk("post_err", o_rsp_err, 0);
  endtask

  initial begin
    vec_t v;
    rst_n     = 1'b0;
    sel       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_ready", o_req_ready, 1);
      chk("rst_valid", o_rsp_valid, 0);
      chk("rst_rdata", o_rsp_rdata, 0);
      chk("rst_err", o_rsp_err, 0);
    end
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    add(1, 32'h10, 32'hDEADBEEF, STRB_WORD, 0, 0, 0);
    add(0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 0);
    add(1, 32'h20, 32'h11223344, STRB_WORD, 0, 0, 0);
    add(1, 32'h20, 32'h0000AABB, STRB_HALF, 0, 0, 0);
    add(1, 32'h20, 32'h000000CC, STRB_BYTE, 0, 0, 0);
    add(0, 32'h20, 32'h0, 4'h0, 5, 32'h1122AACC, 0);
    add(1, 32'h20, 32'h00EE0000, 4'b0100, 0, 0, 0);
    add(0, 32'h20, 32'h0, 4'h0, 0, 32'h11EEAACC, 0);
    add(1, 32'h0, 32'hCAFEF00D, STRB_WORD, 0, 0, 0);
    add(0, 32'h2, 32'h0, 4'h0, 2, 0, 1);
    add(1, 32'h1000, 32'h12345678, STRB_WORD, 0, 0, 1);
    add(0, 32'h0, 32'h0, 4'h0, 0, 32'hCAFEF00D, 0);
    add(1, 32'h0, 32'hFFFFFFFF, 4'b0000, 0, 0, 0);
    add(0, 32'h0, 32'h0, 4'h0, 0, 32'hCAFEF00D, 0);
    add(1, 32'h1, 32'hFFFFFFFF, STRB_WORD, 0, 0, 1);
    add(0, 32'h0, 32'h0, 4'h0, 0, 32'hCAFEF00D, 0);
    add(1, 32'hFFC, 32'h01020304, STRB_WORD, 0, 0, 0);
    add(1, 32'hFFC, 32'hA5A5A5A5, 4'b1100, 0, 0, 0);
    add(0, 32'hFFC, 32'h0, 4'h0, 0, 32'hA5A50304, 0);
    add(0, 32'h1000, 32'h0, 4'h0, 0, 0, 1);
    add(0, 32'h80000000, 32'h0, 4'h0, 0, 0, 1);

    foreach (tbl[i]) xact(tbl[i], 2);

    sel = 1'b1;
    v = '{1, 32'h40, 32'h13579BDF, STRB_WORD, 0, 0, 0};
    xact(v, 4);
    v = '{0, 32'h44, 32'h0, 4'h0, 3, 0, 1};
    v.addr = 32'h46;
    xact(v, 4);

    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h40;
    req_wdata = 32'hFFFFFFFF;
    req_strb  = STRB_WORD;
    chk("mid_pre_ready", o_req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("mid_busy", o_req_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", o_req_ready, 1);
    chk("mid_rst_valid", o_rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_ready", o_req_ready, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_no_rsp", o_rsp_valid, 0);

    v = '{0, 32'h40, 32'h0, 4'h0, 1, 32'h13579BDF, 0};
    xact(v, 4);

    sel = 1'b0;
    v = '{0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 0};
    xact(v, 2);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
